// File: rtl/arbitro_mux_4x1_4b_pkg.sv
// rtl/arbitro_mux_4x1_4b_pkg.sv - shared types, widths and helpers for the round-robin mux arbiter
package arbitro_mux_4x1_4b_pkg;

   localparam int CNT_W = 4;
   localparam int N_REQ = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // First set request bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   // Walking the offsets downward lets the smallest offset overwrite the others.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   function automatic logic [3:0] one_hot(input logic [1:0] idx);
      one_hot = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/arbitro_mux_4x1_4b_if.sv
// rtl/arbitro_mux_4x1_4b_if.sv - requester, mux select and consumer handshake bundle
interface arbitro_mux_4x1_4b_if;

   logic [3:0] req;
   logic [3:0] a0;
   logic [3:0] a1;
   logic [3:0] a2;
   logic [3:0] a3;
   logic       ready;
   logic [3:0] gnt;
   logic       S1;
   logic       S0;
   logic [3:0] D;
   logic       valid;

   modport master (
      input  req, a0, a1, a2, a3, ready,
      output gnt, S1, S0, D, valid
   );

   modport slave (
      output req, a0, a1, a2, a3, ready,
      input  gnt, S1, S0, D, valid
   );

endinterface

// File: rtl/mux_4x1_4b.sv
// rtl/mux_4x1_4b.sv - 4-bit wide 4-to-1 multiplexer selected by {S1,S0}
module mux_4x1_4b (
   input  logic [3:0] a0,
   input  logic [3:0] a1,
   input  logic [3:0] a2,
   input  logic [3:0] a3,
   input  logic       S1,
   input  logic       S0,
   output logic [3:0] D
);

   always_comb begin
      D = a0;
      case ({S1, S0})
         2'b00: D = a0;
         2'b01: D = a1;
         2'b10: D = a2;
         2'b11: D = a3;
      endcase
   end

endmodule

// File: rtl/arbitro_mux_4x1_4b.sv
// rtl/arbitro_mux_4x1_4b.sv - round-robin burst arbiter driving a shared 4x1 4-bit mux
module arbitro_mux_4x1_4b
   import arbitro_mux_4x1_4b_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   arbitro_mux_4x1_4b_if.master  bus
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   state_t           state;
   logic [1:0]       ptr;
   logic [1:0]       sel;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       gnt_r;

   logic             req_sel;
   logic             beat_valid;
   logic             xfer;
   logic             release_now;
   logic [1:0]       winner;

   assign winner      = rr_pick(bus.req, ptr);
   assign req_sel     = bus.req[sel];
   // The beat is not registered: valid follows the granted request directly.
   assign beat_valid  = (state == ST_GRANT) && req_sel;
   assign xfer        = beat_valid && bus.ready;
   assign release_now = !req_sel || (xfer && (cnt == LAST_BEAT));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ptr   <= 2'd0;
         sel   <= 2'd0;
         cnt   <= '0;
         gnt_r <= 4'b0000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|bus.req) begin
                  state <= ST_GRANT;
                  sel   <= winner;
                  gnt_r <= one_hot(winner);
                  cnt   <= '0;
               end
            end
            ST_GRANT: begin
               // sel is kept on release so D keeps showing the last owner's word.
               if (release_now) begin
                  state <= ST_IDLE;
                  gnt_r <= 4'b0000;
                  ptr   <= sel + 2'd1;
                  cnt   <= '0;
               end else if (xfer) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign bus.gnt   = gnt_r;
   assign bus.S1    = sel[1];
   assign bus.S0    = sel[0];
   assign bus.valid = beat_valid;

   mux_4x1_4b u_mux (
      .a0 (bus.a0),
      .a1 (bus.a1),
      .a2 (bus.a2),
      .a3 (bus.a3),
      .S1 (sel[1]),
      .S0 (sel[0]),
      .D  (bus.D)
   );

endmodule

// File: tb/tb_arbitro_mux_4x1_4b.sv
// tb/tb_arbitro_mux_4x1_4b.sv - self-checking bench for arbitro_mux_4x1_4b (MAX_BURST 4 and 1)
module tb_arbitro_mux_4x1_4b;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] a [4];
   logic       ready;

   int n_cmp;
   int n_err;
   bit checking;

   // reference state per instance: owner -1 = nobody granted
   int owner [2];
   int mptr  [2];
   int msel  [2];
   int beats [2];
   int maxb  [2];

   arbitro_mux_4x1_4b_if bus4 ();
   arbitro_mux_4x1_4b_if bus1 ();

   assign bus4.req   = req;
   assign bus4.a0    = a[0];
   assign bus4.a1    = a[1];
   assign bus4.a2    = a[2];
   assign bus4.a3    = a[3];
   assign bus4.ready = ready;
   assign bus1.req   = req;
   assign bus1.a0    = a[0];
   assign bus1.a1    = a[1];
   assign bus1.a2    = a[2];
   assign bus1.a3    = a[3];
   assign bus1.ready = ready;

   arbitro_mux_4x1_4b #(.MAX_BURST(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.master)
   );

   arbitro_mux_4x1_4b #(.MAX_BURST(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model(input int k);
      logic [3:0] g, d;
      logic [1:0] s;
      logic       v;
      logic [3:0] exp_g;
      logic       exp_v;
      if (k == 0) begin
         g = bus4.gnt; s = {bus4.S1, bus4.S0}; v = bus4.valid; d = bus4.D;
      end else begin
         g = bus1.gnt; s = {bus1.S1, bus1.S0}; v = bus1.valid; d = bus1.D;
      end
      exp_g = (owner[k] < 0) ? 4'b0000 : 4'(1 << owner[k]);
      exp_v = (owner[k] >= 0) && req[owner[k]];
      chk($sformatf("mb%0d_gnt", maxb[k]),   32'(g), 32'(exp_g));
      chk($sformatf("mb%0d_sel", maxb[k]),   32'(s), 32'(msel[k]));
      chk($sformatf("mb%0d_valid", maxb[k]), 32'(v), 32'(exp_v));
      chk($sformatf("mb%0d_D", maxb[k]),     32'(d), 32'(a[msel[k]]));
   endtask

   task automatic model_step(input int k);
      int w;
      if (!rst_n) begin
         owner[k] = -1; mptr[k] = 0; msel[k] = 0; beats[k] = 0;
      end else if (owner[k] < 0) begin
         w = -1;
         for (int i = 0; i < 4; i++)
            if (w < 0 && req[(mptr[k] + i) % 4]) w = (mptr[k] + i) % 4;
         if (w >= 0) begin
            owner[k] = w; msel[k] = w; beats[k] = 0;
         end
      end else if (!req[owner[k]]) begin
         mptr[k] = (owner[k] + 1) % 4; owner[k] = -1;
      end else if (ready) begin
         beats[k]++;
         if (beats[k] == maxb[k]) begin
            mptr[k] = (owner[k] + 1) % 4; owner[k] = -1;
         end
      end
   endtask

   task automatic cycle();
      #1;
      if (checking) begin
         check_model(0);
         check_model(1);
      end
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] rr_exp [4];
      logic [3:0] mb1_exp [7];
      int idx;
      n_cmp = 0; n_err = 0; checking = 0;
      maxb[0] = 4; maxb[1] = 1;
      for (int k = 0; k < 2; k++) begin
         owner[k] = -1; mptr[k] = 0; msel[k] = 0; beats[k] = 0;
      end
      rst_n = 1'b0; req = 4'b1111; ready = 1'b1;
      a[0] = 4'h3; a[1] = 4'h5; a[2] = 4'hA; a[3] = 4'hF;
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000;

      cycle();
      checking = 1;

      // reset held with every requester asking
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("rst_gnt", 32'(bus4.gnt), 32'h0);
         chk("rst_sel", 32'({bus4.S1, bus4.S0}), 32'h0);
         chk("rst_valid", 32'(bus4.valid), 32'h0);
         cycle();
      end
      rst_n = 1'b1;
      #1 chk("idle_after_rst", 32'(bus4.gnt), 32'h0);
      cycle();

      // round robin, four beats per grant, one idle cycle between
      for (int g = 0; g < 5; g++) begin
         idx = g % 4;
         for (int b = 0; b < 4; b++) begin
            #1;
            chk($sformatf("rr_gnt_g%0d_b%0d", g, b), 32'(bus4.gnt), 32'(rr_exp[idx]));
            chk($sformatf("rr_valid_g%0d_b%0d", g, b), 32'(bus4.valid), 32'h1);
            chk($sformatf("rr_D_g%0d_b%0d", g, b), 32'(bus4.D), 32'(a[idx]));
            cycle();
         end
         #1 chk($sformatf("rr_turnaround_g%0d", g), 32'(bus4.gnt), 32'h0);
         if (g < 4) cycle();
      end

      // early drop from requester 2
      req = 4'b0100;
      cycle();
      #1 chk("drop_gnt", 32'(bus4.gnt), 32'b0100);
      cycle();
      cycle();
      req = 4'b0000;
      #1 chk("drop_valid_falls", 32'(bus4.valid), 32'h0);
      cycle();
      req = 4'b1001;
      #1 chk("drop_idle", 32'(bus4.gnt), 32'h0);
      cycle();
      #1 chk("drop_next_gnt", 32'(bus4.gnt), 32'b1000);
      repeat (4) cycle();

      // back-pressure on requester 1
      a[1] = 4'h6;
      req = 4'b0010;
      cycle();
      #1 chk("bp_gnt", 32'(bus4.gnt), 32'b0010);
      cycle();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_valid_hold", 32'(bus4.valid), 32'h1);
         chk("bp_D_hold", 32'(bus4.D), 32'h6);
         cycle();
      end
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("bp_still_granted_%0d", i), 32'(bus4.gnt), 32'b0010);
         cycle();
      end
      #1 chk("bp_release", 32'(bus4.gnt), 32'h0);

      // reset in the middle of requester 3's burst
      req = 4'b1000;
      cycle();
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      #1 chk("rstmid_idle", 32'(bus4.gnt), 32'h0);
      req = 4'b1010;
      cycle();
      #1 chk("rstmid_next_gnt", 32'(bus4.gnt), 32'b0010);
      repeat (4) cycle();

      // single-beat bursts on the MAX_BURST=1 instance
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      req = 4'b0101;
      cycle();
      mb1_exp[0] = 4'b0001; mb1_exp[1] = 4'b0000; mb1_exp[2] = 4'b0100; mb1_exp[3] = 4'b0000;
      mb1_exp[4] = 4'b0001; mb1_exp[5] = 4'b0000; mb1_exp[6] = 4'b0100;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk($sformatf("mb1_seq_%0d", i), 32'(bus1.gnt), 32'(mb1_exp[i]));
         chk($sformatf("mb1_valid_%0d", i), 32'(bus1.valid), 32'(mb1_exp[i] != 4'b0000));
         cycle();
      end

      // random traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
               if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) a[i] = 4'($urandom);
         end
         ready = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/arbitro_mux_4x1_4b.md
# arbitro_mux_4x1_4b

Round-robin arbiter and sequencer that shares one 4-bit, 4-to-1 multiplexed data path among four requesters. It grants one requester at a time for a bounded burst and drives the mux select lines S1/S0. It presents the selected 4-bit word to a single downstream consumer with a valid/ready handshake. It sits between four 4-bit producers and the shared bus. The mux datapath is instantiated inside this block.

## Interface
- MAX_BURST, 4: maximum accepted beats per grant; legal range 1..15.

- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- req  input  4  req[i] = requester i has a word on a_i.
- a0, a1, a2, a3  input  4 each  requester data words.
- ready  input  1  consumer accepts the current beat.
- gnt  output  4  one-hot grant, registered; 0 when idle.
- S1, S0  output  1 each  registered mux select; {S1,S0} = index of granted requester.
- D  output  4  selected word, taken from the mux driven by S1/S0.
- valid  output  1  D holds a beat for the consumer.

## Operation
- FSM states are IDLE and GRANT. Registered state: `ptr` (2-bit priority pointer), `sel` (2-bit, drives S1/S0), `cnt` (4-bit beat counter), `gnt`.
- Reset values: state IDLE, gnt = 0000, {S1,S0} = 00, ptr = 0, cnt = 0. With those values, valid = 0 and D = a0.
- IDLE:
  - If req = 0000, stay in IDLE.
  - Otherwise pick the first requester with req set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: state GRANT, sel = winner, gnt = one-hot(winner), cnt = 0.
- GRANT:
  - valid = req[sel], combinational; the beat is not registered.
  - A transfer happens when valid && ready; each transfer increments cnt.
- Release from GRANT to IDLE at the edge where either condition holds:
  - a transfer occurs with cnt == MAX_BURST-1, or
  - req[sel] == 0.
- On release: gnt = 0000, ptr = sel+1 (mod 4); sel and {S1,S0} keep their value.
- ready low during GRANT: hold state, cnt unchanged, D and valid stable. There is no timeout.
- Requests from non-granted requesters are ignored until the next IDLE cycle. Requesters hold req until served; there is no internal queue.
- Simultaneous requests in IDLE are resolved purely by the ptr order.
- Reset asserted mid-burst: all registers return to reset values at that edge, including ptr = 0. The in-flight beat is lost.
- MAX_BURST = 1: release after every accepted beat.

## Timing
- req → gnt/S1/S0: 1 cycle, observed the edge after req is first sampled in IDLE.
- gnt → first valid: 0 cycles. valid is high in the first GRANT cycle if req[sel] is still high.
- Beat throughput: 1 beat per cycle while ready = 1.
- Turnaround: exactly one IDLE cycle between grants; no back-to-back re-grant.
- Burst length: at most MAX_BURST transfers per grant. Maximum service-wait for any continuously requesting requester is 3 × (MAX_BURST+1) + 1 cycles, with ready tied high.
- D changes only when a_sel changes or when S1/S0 update; no glitch requirement.

## Structure
- Shared include arbitro_defs.vh holds:
  - state encodings ST_IDLE = 1'b0, ST_GRANT = 1'b1;
  - counter width CNT_W = 4.
- Sub-module: one instance of the existing mux_4x1_4b.
  - Connections: a0..a3 to the requester words, S1/S0 from the sel register, D to the D output.
  - No second mux copy; the arbiter adds only control logic.
- Priority search: combinational function or block over req rotated by ptr.
- Target size: about 150 RTL lines.

## Test plan
- Reset: assert rst_n = 0 for 2 cycles with req = 1111.
  - Required: gnt = 0000, {S1,S0} = 00, valid = 0 throughout.
  - First edge after release: gnt = 0001.
- Round robin: req = 1111 held, ready = 1, MAX_BURST = 4, a0..a3 = 3, 5, A, F.
  - Required: grant order 0001, 0010, 0100, 1000, 0001.
  - Each grant carries 4 valid beats, with D = 3, 5, A, F respectively.
  - One IDLE cycle between grants.
- Early drop: grant requester 2, then drop req[2] after 2 beats.
  - Required: valid falls the same cycle; next edge IDLE with ptr = 3.
  - With req = 1001, the next grant is 1000.
- Back-pressure: during a grant with a1 = 6, drive ready = 0 for 3 cycles mid-burst.
  - Required: valid = 1, D = 6 stable, cnt frozen.
  - The burst still delivers exactly 4 accepted beats.
- Reset mid-burst: assert rst_n during beat 2 of requester 3.
  - Required: next edge IDLE with ptr = 0.
  - With req = 1010, the next grant is 0010.
- MAX_BURST = 1 with req = 0101:
  - Required: grants alternate 0001, 0100, each with one beat, separated by one IDLE cycle.
